int_decoder: RTL and testbench

Receive-side counterpart of the interrupter generator. Takes an interrupter pulse train arriving asynchronously (fibre receiver pin) and filters and synchronises it. Measures each pulse's width and period in microseconds, in the same units the generator is programmed in, and republishes a safety-gated copy of the pulse to the bridge driver. It cuts off over-long pulses and reports loss of signal.

---
 rtl/int_pkg.sv | 25 ++
 rtl/in_filter.sv | 74 +++++++
 rtl/int_decoder.sv | 162 ++++++++++++++++
 tb/tb_int_decoder.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// ---------------------------------------------------------------------------
// int_pkg -- shared definitions for the interrupter decoder.
//   * state_t  : decoder FSM states
//   * cnt_w()  : register width needed to hold 0..max_val (never below 1)
//   * DEF_*    : default constants, identical to those the generator uses
// ---------------------------------------------------------------------------
package int_pkg;

   localparam int DEF_CLK_MHZ       = 100;
   localparam int DEF_PAR_MAX_VAL   = 255;
   localparam int DEF_PERIOD_MAX_US = 65535;
   localparam int DEF_FILT          = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HIGH  = 2'd1,
      LOW   = 2'd2,
      FAULT = 2'd3
   } state_t;

   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/in_filter.sv
// ---------------------------------------------------------------------------
// in_filter -- synchroniser, run-length filter and edge strobes.
//   clk, rst_n : system clock, asynchronous active-low reset
//   in_raw     : asynchronous interrupter input
//   level      : filtered level; flips after FILT consecutive differing
//                synchronised samples
//   rise, fall : one-cycle strobes, high in the first cycle of the new level
// ---------------------------------------------------------------------------
module in_filter
   import int_pkg::*;
#(
   parameter int FILT = DEF_FILT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic in_raw,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int CW = cnt_w(FILT - 1);
   localparam logic [CW-1:0] RUN_TOP = CW'(FILT - 1);

   logic [1:0]    sync;
   logic [1:0]    flush;
   logic [CW-1:0] run;
   logic          armed;

   // After reset the level reads 0, but the line may really be high. Until
   // FILT genuine low samples have been seen (once the synchroniser has
   // flushed its reset zeros) the filter stays disarmed, so a line that was
   // already high at release never produces a rise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync  <= '0;
         flush <= '0;
         run   <= '0;
         armed <= 1'b0;
         level <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync  <= {sync[0], in_raw};
         flush <= {flush[0], 1'b1};
         rise  <= 1'b0;
         fall  <= 1'b0;
         if (!armed) begin
            if (flush[1] && !sync[1]) begin
               if (run == RUN_TOP) begin
                  armed <= 1'b1;
                  run   <= '0;
               end else begin
                  run <= run + CW'(1);
               end
            end else begin
               run <= '0;
            end
         end else if (sync[1] != level) begin
            if (run == RUN_TOP) begin
               level <= sync[1];
               rise  <= sync[1];
               fall  <= ~sync[1];
               run   <= '0;
            end else begin
               run <= run + CW'(1);
            end
         end else begin
            run <= '0;
         end
      end
   end

endmodule

// File: rtl/int_decoder.sv
// ---------------------------------------------------------------------------
// int_decoder -- receive side of the interrupter link.
//   clk, rst_n : system clock, asynchronous active-low reset
//   in_raw     : asynchronous interrupter input (fibre receiver)
//   out        : gated copy of the filtered pulse for the bridge driver
//   pw_us      : last on-time in us (floor, saturating at PAR_MAX_VAL)
//   period_us  : last rise-to-rise period in us (saturating at PERIOD_MAX_US)
//   meas_stb   : one-cycle strobe when pw_us/period_us update
//   valid      : published measurements describe the current pulse train
//   fault      : on-time limit hit, output cut off until the input falls
// PW_LIMIT_US must not exceed PAR_MAX_VAL (the on-time counter saturates there).
// ---------------------------------------------------------------------------
module int_decoder
   import int_pkg::*;
#(
   parameter int CLK_MHZ       = DEF_CLK_MHZ,
   parameter int PAR_MAX_VAL   = DEF_PAR_MAX_VAL,
   parameter int PW_LIMIT_US   = PAR_MAX_VAL,
   parameter int PERIOD_MAX_US = DEF_PERIOD_MAX_US,
   parameter int FILT          = DEF_FILT
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              in_raw,
   output logic                              out,
   output logic [cnt_w(PAR_MAX_VAL)-1:0]     pw_us,
   output logic [cnt_w(PERIOD_MAX_US)-1:0]   period_us,
   output logic                              meas_stb,
   output logic                              valid,
   output logic                              fault
);

   localparam int PW_W  = cnt_w(PAR_MAX_VAL);
   localparam int PER_W = cnt_w(PERIOD_MAX_US);
   localparam int PRE_W = cnt_w(CLK_MHZ - 1);

   localparam logic [PW_W-1:0]  PW_SAT  = PW_W'(PAR_MAX_VAL);
   localparam logic [PW_W-1:0]  PW_LIM  = PW_W'(PW_LIMIT_US);
   localparam logic [PER_W-1:0] PER_SAT = PER_W'(PERIOD_MAX_US);
   localparam logic [PRE_W-1:0] PRE_TOP = PRE_W'(CLK_MHZ - 1);

   logic level, rise, fall;

   in_filter #(.FILT(FILT)) u_filt (
      .clk    (clk),
      .rst_n  (rst_n),
      .in_raw (in_raw),
      .level  (level),
      .rise   (rise),
      .fall   (fall)
   );

   // ---- us prescaler: the rise cycle is cycle 0 of a new microsecond ----
   logic [PRE_W-1:0] pre, pre_eff;
   logic             tick;

   always_comb begin
      pre_eff = rise ? '0 : pre;
      tick    = (pre_eff == PRE_TOP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pre <= '0;
      else        pre <= tick ? '0 : pre_eff + PRE_W'(1);
   end

   // ---- FSM ----
   state_t state, state_nxt;
   logic   publish, latch, tmo, flt_clr;
   logic [PW_W-1:0]  on_cnt, pw_lat;
   logic [PER_W-1:0] per_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Limits are tested on the registered counts, so a fall arriving in the
   // first cycle the count shows the limit still wins.
   always_comb begin
      state_nxt = state;
      publish   = 1'b0;
      latch     = 1'b0;
      tmo       = 1'b0;
      flt_clr   = 1'b0;
      case (state)
         IDLE:  if (rise) state_nxt = HIGH;
         HIGH: begin
            if (fall) begin
               state_nxt = LOW;
               latch     = 1'b1;
            end else if (on_cnt == PW_LIM) begin
               state_nxt = FAULT;
            end
         end
         LOW: begin
            if (rise) begin
               state_nxt = HIGH;
               publish   = 1'b1;
            end else if (per_cnt == PER_SAT) begin
               state_nxt = IDLE;
               tmo       = 1'b1;
            end
         end
         FAULT: begin
            if (fall) begin
               state_nxt = IDLE;
               flt_clr   = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---- saturating on-time / period counters ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         on_cnt  <= '0;
         per_cnt <= '0;
         pw_lat  <= '0;
      end else begin
         if (rise) begin
            // a tick in the rise cycle (CLK_MHZ == 1) belongs to the new pulse
            on_cnt  <= PW_W'(tick);
            per_cnt <= PER_W'(tick);
         end else if (state == IDLE) begin
            on_cnt  <= '0;
            per_cnt <= '0;
         end else begin
            if (tick && state == HIGH && level && on_cnt != PW_SAT)
               on_cnt <= on_cnt + PW_W'(1);
            if (tick && (state == HIGH || state == LOW) && per_cnt != PER_SAT)
               per_cnt <= per_cnt + PER_W'(1);
         end
         if (latch) pw_lat <= on_cnt;
      end
   end

   // ---- output registers ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out       <= 1'b0;
         meas_stb  <= 1'b0;
         valid     <= 1'b0;
         pw_us     <= '0;
         period_us <= '0;
      end else begin
         out      <= (state_nxt == HIGH);
         meas_stb <= publish;
         if (publish) begin
            pw_us     <= pw_lat;
            period_us <= per_cnt;
            valid     <= 1'b1;
         end else if (tmo || flt_clr) begin
            valid <= 1'b0;
         end
      end
   end

   assign fault = (state == FAULT);

endmodule

// File: tb/tb_int_decoder.sv
// Randomised + directed bench for int_decoder. Stimulus changes just after a
// rising clock edge; the reference model works on those edge timestamps.
module tb_int_decoder;
   localparam int CLK_MHZ = 5;
   localparam int PMAX    = 255;
   localparam int PERMAX  = 1023;
   localparam int FILT    = 4;
   localparam int LAG     = 7;                 // in_raw -> out, in cycles
   localparam int PW_LIM_CYC  = PMAX * CLK_MHZ;
   localparam int PER_LIM_CYC = PERMAX * CLK_MHZ;

   logic       clk = 1'b0, rst_n = 1'b0, in_raw = 1'b0;
   logic       out, meas_stb, valid, fault;
   logic [7:0] pw_us;
   logic [9:0] period_us;

   int_decoder #(.CLK_MHZ(CLK_MHZ), .PAR_MAX_VAL(PMAX), .PW_LIMIT_US(PMAX),
                 .PERIOD_MAX_US(PERMAX), .FILT(FILT)) dut (
      .clk(clk), .rst_n(rst_n), .in_raw(in_raw), .out(out), .pw_us(pw_us),
      .period_us(period_us), .meas_stb(meas_stb), .valid(valid), .fault(fault));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_chk = 0, n_err = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // ---- reference model: pulse-level view of the link ----
   bit have_ref = 0, valid_m = 0, lvl_m = 0;
   int r_t = 0, f_t = 0;
   int exp_pw[$], exp_per[$], got_pw[$], got_per[$];

   task automatic m_timeout(input int t);
      if (have_ref && !lvl_m && (t - r_t) > PER_LIM_CYC) begin
         have_ref = 0;
         valid_m  = 0;
      end
   endtask

   task automatic m_rise(input int t);
      int w;
      m_timeout(t);
      if (have_ref) begin
         w = (f_t - r_t) / CLK_MHZ;
         exp_pw.push_back(w > PMAX ? PMAX : w);
         exp_per.push_back((t - r_t) / CLK_MHZ);
         valid_m = 1;
      end
      have_ref = 1;
      r_t      = t;
      lvl_m    = 1;
   endtask

   task automatic m_fall(input int t);
      lvl_m = 0;
      if ((t - r_t) > PW_LIM_CYC) begin
         have_ref = 0;
         valid_m  = 0;
      end else begin
         f_t = t;
      end
   endtask

   task automatic chk_valid(input string tag);
      m_timeout(cyc - LAG - 2);
      chk(tag, valid, valid_m);
   endtask

   task automatic cmp_meas(input string tag);
      int n;
      chk({tag, "_n"}, got_pw.size(), exp_pw.size());
      n = (got_pw.size() < exp_pw.size()) ? got_pw.size() : exp_pw.size();
      for (int i = 0; i < n; i++) begin
         chk({tag, "_pw"}, got_pw[i], exp_pw[i]);
         chk({tag, "_per"}, got_per[i], exp_per[i]);
      end
      got_pw.delete(); got_per.delete(); exp_pw.delete(); exp_per.delete();
   endtask

   // ---- monitors ----
   always @(negedge clk)
      if (meas_stb === 1'b1) begin
         got_pw.push_back(pw_us);
         got_per.push_back(period_us);
      end

   bit       mir_en = 0;
   logic [7:0] hist = '0;
   always @(negedge clk) begin
      if (mir_en) chk("mirror", out, hist[LAG-1]);
      hist <= {hist[6:0], in_raw};
   end

   // ---- stimulus helpers ----
   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse(input int h, input int l);
      m_rise(cyc); in_raw = 1'b1; wait_cyc(h);
      m_fall(cyc); in_raw = 1'b0; wait_cyc(l);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_out"}, out, 0);
      chk({tag, "_pw"}, pw_us, 0);
      chk({tag, "_per"}, period_us, 0);
      chk({tag, "_stb"}, meas_stb, 0);
      chk({tag, "_valid"}, valid, 0);
      chk({tag, "_fault"}, fault, 0);
   endtask

   initial begin
      #2;
      chk_zero("rst");
      wait_cyc(3);
      rst_n = 1'b1;
      wait_cyc(20);

      // A: steady 20 us / 200 us train, out must mirror the input
      mir_en = 1;
      repeat (10) pulse(20 * CLK_MHZ, 180 * CLK_MHZ);
      mir_en = 0;
      chk("A_pw", pw_us, 20);
      chk("A_per", period_us, 200);
      chk("A_valid", valid, 1);
      cmp_meas("A");

      // B: low glitch inside a pulse, high glitch on the low line
      m_rise(cyc); in_raw = 1'b1; wait_cyc(30);
      in_raw = 1'b0; wait_cyc(3);
      in_raw = 1'b1; wait_cyc(20);
      chk("B_lowgl_out", out, 1);
      wait_cyc(27);
      m_fall(cyc); in_raw = 1'b0; wait_cyc(400);
      in_raw = 1'b1; wait_cyc(3);
      in_raw = 1'b0; wait_cyc(20);
      chk("B_highgl_out", out, 0);
      wait_cyc(477);
      pulse(100, 900);
      cmp_meas("B");

      // C: limit / timeout boundaries, then random pulses
      pulse(PW_LIM_CYC + 1, 300);
      pulse(100, PER_LIM_CYC - 100);
      pulse(100, PER_LIM_CYC - 99);
      pulse(100, 900);
      repeat (12) pulse($urandom_range(FILT + 1, 400), $urandom_range(FILT + 1, 600));
      wait_cyc(20);
      cmp_meas("C");
      chk_valid("C_valid");

      // D: input stuck high for 300 us
      m_rise(cyc); in_raw = 1'b1; wait_cyc(254 * CLK_MHZ);
      chk("D_out_pre", out, 1);
      chk("D_fault_pre", fault, 0);
      wait_cyc(30);
      chk("D_out_cut", out, 0);
      chk("D_fault", fault, 1);
      wait_cyc(300 * CLK_MHZ - 254 * CLK_MHZ - 30);
      m_fall(cyc); in_raw = 1'b0; wait_cyc(20);
      chk("D_fault_clr", fault, 0);
      chk("D_valid", valid, 0);
      chk_valid("D_valid_m");
      wait_cyc(480);
      cmp_meas("D");

      // E: loss of signal
      pulse(100, 900);
      pulse(100, 900);
      chk("E_valid_on", valid, 1);
      wait_cyc(5000);
      chk("E_valid_off", valid, 0);
      chk_valid("E_valid_m");
      pulse(100, 900);
      pulse(100, 900);
      chk("E_n", got_pw.size(), 2);
      cmp_meas("E");

      // F: reset in mid-pulse, line still high at release
      m_rise(cyc); in_raw = 1'b1; wait_cyc(50);
      cmp_meas("F_pre");
      rst_n = 1'b0; #1;
      have_ref = 0; valid_m = 0; lvl_m = 0;
      chk_zero("F_rst");
      wait_cyc(5);
      rst_n = 1'b1;
      wait_cyc(300);
      chk("F_out_held", out, 0);
      chk("F_valid_held", valid, 0);
      chk("F_no_meas", got_pw.size(), 0);
      in_raw = 1'b0; wait_cyc(100);
      pulse(100, 900);
      pulse(100, 900);
      cmp_meas("F");

      // G: 1 us / 5 us, then exactly the on-time limit
      pulse(CLK_MHZ, 4 * CLK_MHZ);
      pulse(PW_LIM_CYC, 100 * CLK_MHZ);
      chk("G_pw1", pw_us, 1);
      chk("G_per5", period_us, 5);
      chk("G_valid", valid, 1);
      pulse(100, 900);
      chk("G_pw255", pw_us, 255);
      chk("G_per", period_us, 355);
      chk("G_fault", fault, 0);
      cmp_meas("G");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #3000000;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
